// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one producer-side handshake fanning out to N consumer lanes.
// The slave modport is the demux's own view; master is the view of whatever drives and consumes it.
interface demux_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic               drop;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop
  );
endinterface

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demux, routed by in_sel (MODE 0) or round-robin (MODE 1).
// Define DEMUX_STATS_EN to add the cnt port with per-channel saturating 8-bit transfer counters.
module demux_stream #(
  parameter int               WIDTH = 8,
  parameter int               N     = 4,
  parameter int               SEL_W = 2,
  parameter logic [WIDTH-1:0] IDLE  = {WIDTH{1'b1}},
  parameter int               MODE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_stream_if.slave     bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [N*8-1:0]    cnt
`endif
);

  logic [N*WIDTH-1:0] data_q;
  logic [N-1:0]       valid_q;
  logic [SEL_W-1:0]   rr;
  logic               drop_q;

  logic [SEL_W-1:0]   tgt;
  logic               in_range;
  logic [N-1:0]       free;
  logic               tgt_free;
  logic               accept;
  logic [N-1:0]       wr;

  assign tgt      = (MODE == 1) ? rr : bus.in_sel;
  assign in_range = int'(tgt) < N;
  assign free     = ~valid_q | bus.out_ready;

  // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = free[k];
    end
  end

  // An out-of-range select is always accepted so a bad producer cannot wedge the stream.
  assign bus.in_ready = !in_range || tgt_free;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    wr = '0;
    for (int k = 0; k < N; k++) begin
      wr[k] = accept && in_range && (tgt == SEL_W'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= {N{IDLE}};
      rr      <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= accept && !in_range;
      for (int k = 0; k < N; k++) begin
        // A write wins over a pop on the same channel, which gives back-to-back beats without a bubble.
        if (wr[k]) begin
          data_q[k*WIDTH +: WIDTH] <= bus.in_data;
          valid_q[k]               <= 1'b1;
        end else if (valid_q[k] && bus.out_ready[k]) begin
          data_q[k*WIDTH +: WIDTH] <= IDLE;
          valid_q[k]               <= 1'b0;
        end
      end
      if (MODE == 1 && accept) begin
        rr <= (rr == SEL_W'(N - 1)) ? '0 : rr + SEL_W'(1);
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.drop      = drop_q;

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [N];

  // NOTE: the counter array is small and architecturally visible, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr[k] && cnt_q[k] != 8'hFF) cnt_q[k] <= cnt_q[k] + 8'd1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < N; k++) cnt[k*8 +: 8] = cnt_q[k];
  end
`endif

endmodule
